// File: rtl/prog_loader.sv
// Framed program loader: hunts a sync byte, parses an address/length header, packs payload
// bytes little-endian into memory words with byte enables and verifies an 8-bit checksum.
module prog_loader #(
    parameter int         DATA_W   = 32,
    parameter int         ADDR_W   = 32,
    parameter int         MEM_SIZE = 32768,
    parameter logic [7:0] SYNC     = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                progEn,
    input  logic                rxFfEmpty,
    output logic                rxRdEn,
    input  logic [7:0]          rxData,
    output logic                memWrEn,
    input  logic                memReady,
    output logic [ADDR_W-1:0]   memAddr,
    output logic [DATA_W-1:0]   memData,
    output logic [DATA_W/8-1:0] memBe,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err
);

    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [1:0] ERR_CSUM  = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;
    localparam logic [1:0] ERR_ALIGN = 2'd3;

    typedef enum logic [2:0] {
        IDLE, HDR_ADDR, HDR_LEN, PAYLOAD, CSUM, WRITE, DONE, ERROR
    } state_t;

    state_t state, stateNext;

    logic              rxVld;
    logic [1:0]        hdrCnt;
    logic [31:0]       hdrAddr;
    logic [15:0]       remLen;
    logic [7:0]        sum;
    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] wordBuf;
    logic [BYTES-1:0]  beBuf;
    logic [ADDR_W-1:0] wrAddr;
    logic              doneReg;
    logic [1:0]        errReg;

    logic        needByte, capture, accept;
    logic [7:0]  sumNext;
    logic [15:0] lenFull;
    logic [32:0] frameEnd;
    logic        misaligned, outOfRange, lastByte, wordFull;

    function automatic logic [7:0] csumAdd(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    // A byte requested last cycle is on rxData now; progEn low discards it.
    assign capture    = rxVld & progEn;
    assign memWrEn    = (state == WRITE) & progEn;
    assign accept     = memWrEn & memReady;
    assign sumNext    = csumAdd(sum, rxData);
    assign lenFull    = {rxData, remLen[7:0]};
    assign frameEnd   = {1'b0, hdrAddr} + {17'd0, lenFull};
    assign misaligned = (hdrAddr & 32'(BYTES - 1)) != 32'd0;
    assign outOfRange = frameEnd > 33'(MEM_SIZE);
    assign lastByte   = (remLen == 16'd1);
    assign wordFull   = (lane == LANE_W'(BYTES - 1));

    assign needByte = (state == IDLE) || (state == HDR_ADDR) || (state == HDR_LEN) ||
                      (state == PAYLOAD) || (state == CSUM);
    assign rxRdEn   = progEn & ~rst & ~rxFfEmpty & needByte & ~rxVld & ~memWrEn;
    assign busy     = (state == HDR_ADDR) || (state == HDR_LEN) || (state == PAYLOAD) ||
                      (state == CSUM) || (state == WRITE);

    assign memAddr = wrAddr;
    assign memData = wordBuf;
    assign memBe   = beBuf;
    assign done    = doneReg;
    assign err     = errReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (!progEn) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:     if (capture && rxData == SYNC) stateNext = HDR_ADDR;
                HDR_ADDR: if (capture && hdrCnt == 2'd3) stateNext = HDR_LEN;
                HDR_LEN: begin
                    if (capture && hdrCnt == 2'd1) begin
                        if (misaligned || outOfRange) stateNext = ERROR;
                        else if (lenFull == 16'd0)    stateNext = CSUM;
                        else                          stateNext = PAYLOAD;
                    end
                end
                PAYLOAD:  if (capture && (wordFull || lastByte)) stateNext = WRITE;
                WRITE:    if (accept) stateNext = (remLen == 16'd0) ? CSUM : PAYLOAD;
                CSUM:     if (capture) stateNext = (sumNext == 8'd0) ? DONE : ERROR;
                default:  stateNext = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || !progEn) begin
            rxVld   <= 1'b0;
            hdrCnt  <= '0;
            hdrAddr <= '0;
            remLen  <= '0;
            sum     <= '0;
            lane    <= '0;
            wordBuf <= '0;
            beBuf   <= '0;
            wrAddr  <= '0;
            doneReg <= 1'b0;
            errReg  <= '0;
        end else begin
            rxVld <= rxRdEn;
            if (capture) begin
                case (state)
                    IDLE: begin
                        if (rxData == SYNC) begin
                            hdrCnt  <= '0;
                            hdrAddr <= '0;
                            remLen  <= '0;
                            sum     <= '0;
                            lane    <= '0;
                            wordBuf <= '0;
                            beBuf   <= '0;
                        end
                    end
                    HDR_ADDR: begin
                        hdrAddr <= {rxData, hdrAddr[31:8]};
                        hdrCnt  <= hdrCnt + 2'd1;
                        sum     <= sumNext;
                    end
                    HDR_LEN: begin
                        hdrCnt <= hdrCnt + 2'd1;
                        sum    <= sumNext;
                        if (hdrCnt == 2'd0) begin
                            remLen[7:0] <= rxData;
                        end else begin
                            remLen <= lenFull;
                            wrAddr <= ADDR_W'(hdrAddr);
                            if (misaligned)      errReg <= ERR_ALIGN;
                            else if (outOfRange) errReg <= ERR_RANGE;
                        end
                    end
                    PAYLOAD: begin
                        for (int k = 0; k < BYTES; k++) begin
                            if (lane == LANE_W'(k)) begin
                                wordBuf[8*k +: 8] <= rxData;
                                beBuf[k]          <= 1'b1;
                            end
                        end
                        lane   <= lane + 1'b1;
                        remLen <= remLen - 16'd1;
                        sum    <= sumNext;
                    end
                    CSUM: begin
                        sum <= sumNext;
                        if (sumNext == 8'd0) doneReg <= 1'b1;
                        else                 errReg  <= ERR_CSUM;
                    end
                    default: ;
                endcase
            end
            // Accepted word: advance to the next word address and start an empty buffer.
            if (accept) begin
                wrAddr  <= wrAddr + ADDR_W'(BYTES);
                wordBuf <= '0;
                beBuf   <= '0;
                lane    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: models the RX FIFO, records accepted memory writes and compares
// them against expected writes queued alongside each frame.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst, progEn, rxFfEmpty, rxRdEn;
    logic [7:0]  rxData;
    logic        memWrEn, memReady;
    logic [31:0] memAddr, memData;
    logic [3:0]  memBe;
    logic        busy, done;
    logic [1:0]  err;

    always #5 clk = ~clk;

    prog_loader #(.DATA_W(32), .ADDR_W(32), .MEM_SIZE(1024), .SYNC(8'hA5)) dut (
        .clk(clk), .rst(rst), .progEn(progEn), .rxFfEmpty(rxFfEmpty), .rxRdEn(rxRdEn),
        .rxData(rxData), .memWrEn(memWrEn), .memReady(memReady), .memAddr(memAddr),
        .memData(memData), .memBe(memBe), .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    int         wrCycles = 0;
    logic [7:0] rxQ[$];
    wr_t        expQ[$];
    wr_t        obsQ[$];

    // One clock: sample at the falling edge, then serve the FIFO read after the rising edge.
    task automatic step();
        logic rdPrev;
        wr_t  w;
        if (memWrEn === 1'b1) wrCycles++;
        if (memWrEn === 1'b1 && memReady === 1'b1) begin
            w.addr = memAddr;
            w.data = memData;
            w.be   = memBe;
            obsQ.push_back(w);
        end
        rdPrev = rxRdEn;
        @(posedge clk);
        #1;
        if (rdPrev === 1'b1 && rxQ.size() > 0) rxData = rxQ.pop_front();
        rxFfEmpty = (rxQ.size() == 0);
        @(negedge clk);
    endtask

    task automatic pushByte(input logic [7:0] b);
        rxQ.push_back(b);
        rxFfEmpty = 1'b0;
    endtask

    task automatic pushFrameA(input logic [7:0] csum);
        logic [7:0] fr [13];
        fr = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        foreach (fr[i]) pushByte(fr[i]);
        pushByte(csum);
    endtask

    task automatic pushFrameB();
        logic [7:0] fr [11];
        fr = '{8'hA5, 8'h20, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hAC};
        foreach (fr[i]) pushByte(fr[i]);
    endtask

    task automatic expectFrameA();
        expQ.push_back('{addr: 32'h10, data: 32'h44332211, be: 4'b1111});
        expQ.push_back('{addr: 32'h14, data: 32'h00006655, be: 4'b0011});
    endtask

    task automatic startFrame();
        progEn    = 1'b0;
        memReady  = 1'b1;
        rxQ.delete();
        expQ.delete();
        obsQ.delete();
        rxFfEmpty = 1'b1;
        wrCycles  = 0;
        step();
        progEn = 1'b1;
    endtask

    task automatic waitStatus(input int budget, output bit timedOut);
        int n;
        n = 0;
        while (done !== 1'b1 && err === 2'd0 && n < budget) begin
            step();
            n++;
        end
        timedOut = (done !== 1'b1 && err === 2'd0);
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; progEn = 1'b1; rxFfEmpty = 1'b0; memReady = 1'b1; rxData = 8'h00;
        @(negedge clk);
        checks++;
        if ({rxRdEn, memWrEn, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: rd/wr/busy/done=%b want 0000", {rxRdEn, memWrEn, busy, done});
        end
        checks++;
        if (err !== 2'd0) begin errors++; $display("FAIL reset_err: err=%0d want 0", err); end
        checks++;
        if (memAddr !== 32'd0 || memData !== 32'd0) begin
            errors++;
            $display("FAIL reset_mem: addr=%h data=%h want 0", memAddr, memData);
        end
        checks++;
        if (memBe !== 4'd0) begin errors++; $display("FAIL reset_be: be=%b want 0000", memBe); end
        progEn = 1'b0; rxFfEmpty = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_good_frame();
        bit to;
        wr_t e, o;
        startFrame();
        pushFrameA(8'h85);
        expectFrameA();
        waitStatus(200, to);
        checks++;
        if (to) begin errors++; $display("FAIL good_timeout: no status after 200 cycles"); end
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            errors++; $display("FAIL good_count: writes=%0d want %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL good_write: got %h/%h/%b want %h/%h/%b", o.addr, o.data, o.be, e.addr, e.data, e.be);
            end
        end
        checks++;
        if (done !== 1'b1 || err !== 2'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL good_status: done=%b err=%0d busy=%b want 1/0/0", done, err, busy);
        end
    endtask

    task automatic test_bad_checksum();
        bit to;
        wr_t e, o;
        startFrame();
        pushFrameA(8'h84);
        expectFrameA();
        waitStatus(200, to);
        checks++;
        if (to) begin errors++; $display("FAIL csum_timeout: no status after 200 cycles"); end
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            errors++; $display("FAIL csum_count: writes=%0d want %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL csum_write: got %h/%h/%b want %h/%h/%b", o.addr, o.data, o.be, e.addr, e.data, e.be);
            end
        end
        checks++;
        if (done !== 1'b0 || err !== 2'd1) begin
            errors++; $display("FAIL csum_status: done=%b err=%0d want 0/1", done, err);
        end
    endtask

    task automatic test_range();
        bit to;
        startFrame();
        pushByte(8'hA5); pushByte(8'hFC); pushByte(8'h03); pushByte(8'h00); pushByte(8'h00);
        pushByte(8'h08); pushByte(8'h00);
        for (int i = 0; i < 9; i++) pushByte(8'(i + 1));
        waitStatus(200, to);
        repeat (4) step();
        checks++;
        if (to || err !== 2'd2 || done !== 1'b0) begin
            errors++; $display("FAIL range_status: err=%0d done=%b want 2/0", err, done);
        end
        checks++;
        if (wrCycles !== 0) begin errors++; $display("FAIL range_writes: memWrEn cycles=%0d want 0", wrCycles); end
        checks++;
        if (rxQ.size() !== 9) begin errors++; $display("FAIL range_reads: bytes left=%0d want 9", rxQ.size()); end
    endtask

    task automatic test_misaligned();
        bit to;
        startFrame();
        pushByte(8'hA5); pushByte(8'h11); pushByte(8'h00); pushByte(8'h00); pushByte(8'h00);
        pushByte(8'h04); pushByte(8'h00);
        pushByte(8'h01); pushByte(8'h02); pushByte(8'h03); pushByte(8'h04); pushByte(8'hE3);
        waitStatus(200, to);
        checks++;
        if (to || err !== 2'd3 || done !== 1'b0) begin
            errors++; $display("FAIL align_status: err=%0d done=%b want 3/0", err, done);
        end
        checks++;
        if (wrCycles !== 0) begin errors++; $display("FAIL align_writes: memWrEn cycles=%0d want 0", wrCycles); end
    endtask

    task automatic test_leading_junk();
        bit to;
        wr_t e, o;
        startFrame();
        pushByte(8'h00); pushByte(8'hFF); pushByte(8'h5A);
        pushFrameA(8'h85);
        expectFrameA();
        waitStatus(200, to);
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            errors++; $display("FAIL junk_count: writes=%0d want %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL junk_write: got %h/%h/%b want %h/%h/%b", o.addr, o.data, o.be, e.addr, e.data, e.be);
            end
        end
        checks++;
        if (to || done !== 1'b1 || err !== 2'd0) begin
            errors++; $display("FAIL junk_status: done=%b err=%0d want 1/0", done, err);
        end
    endtask

    task automatic test_stall();
        bit to;
        int n;
        wr_t e, o;
        startFrame();
        memReady = 1'b0;
        pushFrameA(8'h85);
        expectFrameA();
        n = 0;
        while (memWrEn !== 1'b1 && n < 100) begin step(); n++; end
        checks++;
        if (memWrEn !== 1'b1) begin errors++; $display("FAIL stall_start: memWrEn=%b want 1", memWrEn); end
        for (int k = 0; k < 4; k++) begin
            if (k == 3) memReady = 1'b1;
            checks++;
            if (memWrEn !== 1'b1 || memAddr !== 32'h10 || memData !== 32'h44332211 ||
                memBe !== 4'hF || rxRdEn !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: wr=%b addr=%h data=%h be=%b rd=%b want 1/10/44332211/1111/0",
                         k, memWrEn, memAddr, memData, memBe, rxRdEn);
            end
            step();
        end
        waitStatus(200, to);
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            errors++; $display("FAIL stall_count: writes=%0d want %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall_write: got %h/%h/%b want %h/%h/%b", o.addr, o.data, o.be, e.addr, e.data, e.be);
            end
        end
        checks++;
        if (to || done !== 1'b1 || wrCycles !== 5) begin
            errors++; $display("FAIL stall_status: done=%b memWrEn cycles=%0d want 1/5", done, wrCycles);
        end
    endtask

    task automatic test_abort(input bit useRst);
        bit to;
        int n;
        wr_t e, o;
        startFrame();
        pushFrameA(8'h85);
        n = 0;
        while (memBe === 4'h0 && n < 100) begin step(); n++; end
        checks++;
        if (memBe === 4'h0) begin errors++; $display("FAIL abort_start%0d: payload never began", useRst); end
        if (useRst) begin
            rst = 1'b1;
            #1;
        end else begin
            progEn = 1'b0;
            step();
        end
        checks++;
        if ({rxRdEn, memWrEn, busy, done} !== 4'b0000 || err !== 2'd0 ||
            memAddr !== 32'd0 || memData !== 32'd0 || memBe !== 4'd0) begin
            errors++;
            $display("FAIL abort_clear%0d: rd/wr/busy/done=%b err=%0d addr=%h data=%h be=%b want all 0",
                     useRst, {rxRdEn, memWrEn, busy, done}, err, memAddr, memData, memBe);
        end
        checks++;
        if (obsQ.size() !== 0) begin errors++; $display("FAIL abort_early%0d: writes=%0d want 0", useRst, obsQ.size()); end
        if (useRst) begin
            @(negedge clk);
            rst = 1'b0;
        end
        rxQ.delete();
        rxFfEmpty = 1'b1;
        step();
        progEn = 1'b1;
        pushFrameB();
        expQ.push_back('{addr: 32'h20, data: 32'h00CCBBAA, be: 4'b0111});
        waitStatus(200, to);
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            errors++; $display("FAIL abort_count%0d: writes=%0d want %0d", useRst, obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_write%0d: got %h/%h/%b want %h/%h/%b", useRst, o.addr, o.data, o.be, e.addr, e.data, e.be);
            end
        end
        checks++;
        if (to || done !== 1'b1 || err !== 2'd0) begin
            errors++; $display("FAIL abort_status%0d: done=%b err=%0d want 1/0", useRst, done, err);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_range();
        test_misaligned();
        test_leading_junk();
        test_stall();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Framed, parametrised boot/program loader that replaces the raw byte-stream programmer. It sits between the UART RX FIFO and the instruction/data memory write port. It hunts for a sync byte and parses a header carrying the start address and length. It packs payload bytes little-endian into DATA_W-bit words with byte enables, handshakes each word into memory, and checks an 8-bit checksum, reporting busy/done/error status to the host-control logic.

## Interface
- DATA_W, 32, memory word width in bits; 8, 16 or 32; BYTES = DATA_W/8
- ADDR_W, 32, memory byte-address width
- MEM_SIZE, 32768, memory size in bytes; valid addresses are 0..MEM_SIZE-1
- SYNC, 8'hA5, frame sync byte
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- progEn  in  1  loader enable; low forces IDLE and clears status
- rxFfEmpty  in  1  RX FIFO empty
- rxRdEn  out  1  RX FIFO read pulse
- rxData  in  8  RX FIFO data, valid the cycle after rxRdEn
- memWrEn  out  1  write request, held until accepted
- memReady  in  1  memory accepts the write when memWrEn & memReady
- memAddr  out  ADDR_W  word-aligned byte address
- memData  out  DATA_W  write data
- memBe  out  BYTES  byte enables; bit k covers memData[8k+7:8k]
- busy  out  1  frame in progress (any state except IDLE/DONE/ERROR)
- done  out  1  frame completed, checksum good; sticky
- err  out  2  0 none, 1 checksum, 2 range/overflow, 3 misaligned address; sticky

## Operation
- States: IDLE (sync hunt), HDR_ADDR (4 bytes, LSB first), HDR_LEN (2 bytes, LSB first, length in bytes), PAYLOAD, CSUM, WRITE, DONE, ERROR.
- IDLE: consume bytes and discard any byte != SYNC. SYNC moves to HDR_ADDR and clears the running sum.
- Running sum: 8-bit modulo-256 sum of all address, length, payload and checksum bytes. SYNC is excluded. The frame is good iff the final sum == 0.
- After the last length byte:
  - addr % BYTES != 0 -> ERROR, err=3.
  - addr + len > MEM_SIZE (ADDR_W+1-bit compare) -> ERROR, err=2.
  - len == 0 -> CSUM.
  - Otherwise -> PAYLOAD.
  - No memory write occurs in any error case.
- PAYLOAD:
  - Byte i goes to lane (i % BYTES) of the word buffer, and the corresponding memBe bit is set.
  - When the lane buffer is full or the last payload byte arrives -> WRITE.
  - Unwritten lanes are 0 with memBe bit 0.
- WRITE:
  - memWrEn=1 with a stable addr/data/be.
  - On memWrEn & memReady: addr += BYTES, buffer and memBe cleared; go to PAYLOAD if bytes remain, else CSUM.
- CSUM: consume 1 byte. Sum == 0 -> DONE (done=1); else ERROR, err=1. Writes already made are not undone.
- DONE/ERROR: no further rx reads; status holds until progEn falls.
- progEn low in any state -> IDLE next cycle, status cleared, and any pending memWrEn dropped. A byte in flight is discarded.

## Timing
- Reset: all outputs 0; state IDLE; address, length, sum and buffer cleared.
- rxRdEn = progEn & !rxFfEmpty & (state needs a byte) & (no byte in flight) & !memWrEn. It is a single-cycle pulse.
- rxData is captured the cycle after rxRdEn. The next rxRdEn may assert no earlier than that capture cycle, giving a maximum of 1 byte per 2 clocks.
- The capture of the word-completing byte moves the FSM to WRITE. memWrEn rises the following cycle, i.e. 2 cycles after the final rxRdEn.
- With memReady tied high, each write lasts exactly 1 cycle. memReady low stalls indefinitely with all mem outputs stable.
- Last payload word with fewer than BYTES bytes: partial memBe, contiguous from lane 0.
- done/err rise the cycle after the deciding byte is captured.
- Asynchronous rst mid-frame: immediate return to reset values; no resumption.

## Test plan
- DATA_W=32, MEM_SIZE=1024. Stream A5 10 00 00 00 06 00 11 22 33 44 55 66 85 -> two writes:
  - 0x10 / 0x44332211 / be 1111
  - 0x14 / 0x00006655 / be 0011
  - Then done=1, err=0.
- Same frame with checksum 0x84 -> both writes occur, then err=1, done=0.
- Header addr 0x3FC, len 8 -> err=2, zero memWrEn pulses. Header addr 0x11 -> err=3.
- Leading bytes 00 FF 5A before A5 -> discarded; the frame from test 1 still yields identical writes.
- memReady low for 3 cycles on the first write -> memWrEn, memAddr, memData and memBe held for 4 cycles; rxRdEn stays 0 throughout.
- progEn dropped mid-payload, then re-raised with a fresh frame -> outputs clear next cycle, and the new frame loads correctly. The same scenario with an rst pulse gives the same result.
